key_event_ctrl: RTL
===================

// Module: key_event_ctrl
// PURPOSE
//   Controller for the board push-button bank on the P8 bus.
//   - Synchronises and debounces N_KEYS raw active-low keys.
//   - Latches press events into a write-1-to-clear PENDING register and raises a maskable level IRQ to the CPU.
//   - Gives the CPU a register interface: debounced STATE, PENDING, MASK, CTRL. A registered read takes one cycle.
// PARAMETERS
//   N_KEYS          8       number of keys, 1..16
//   TICK_DIV        250000  clk cycles per debounce sample tick (>=2)
//   STABLE_SAMPLES  4       consecutive agreeing samples needed to change debounced level (2..8)
// PORTS
//   clk       in   1       system clock
//   reset     in   1       synchronous, active-high
//   user_key  in   N_KEYS  raw keys, active-low, asynchronous to clk
//   addr      in   2       word select, byte address bits [3:2]
//   we        in   1       write strobe, one cycle
//   wdata     in   32      write data
//   rdata     out  32      read data, registered, valid the cycle after addr is presented
//   irq       out  1       level interrupt request, registered
// BEHAVIOUR
//   Clock and reset: clk. Reset is synchronous, active-high. It clears every register and counter;
//     rdata=0, irq=0, STATE=0 (all released), PENDING=0, MASK=0, CTRL=0.
//   Register map (addr):
//     0 STATE    RO  bit i = debounced key i, 1 = pressed
//     1 PENDING  W1C press events in [N_KEYS-1:0]; release events in [N_KEYS+15:16] (see CONFIGURATION)
//     2 MASK     RW  [N_KEYS-1:0], per-key IRQ enable; other bits read 0
//     3 CTRL     RW  bit0 EN (global IRQ enable), bit1 FREEZE (stop debounce ticks); other bits read 0
//   Input path: 2-FF synchroniser per key, then inversion (pressed=1).
//   Tick counter: counts 0..TICK_DIV-1 and wraps. tick pulses for one cycle at the wrap. While FREEZE=1 the
//     counter holds, no ticks occur, and STATE and the sample histories hold.
//   Per-key debounce on each tick:
//     - Shift the synchronised sample into a STABLE_SAMPLES-bit history.
//     - If all bits equal and differ from STATE[i], STATE[i] takes that value in the same cycle.
//     - A key that toggles faster than STABLE_SAMPLES ticks never changes STATE.
//   Event set: the cycle after STATE[i] goes 0->1, PENDING[i] is set. Several keys may set in the same cycle.
//   Write to PENDING: clears each bit whose wdata bit is 1. If a set and a clear hit the same bit in the same
//     cycle, the set wins. Writes to STATE are ignored.
//   irq <= EN & |(PENDING[N_KEYS-1:0] & MASK), registered one cycle after the state changes.
//     irq stays high until the contributing bits are cleared or masked.
//   Read: rdata <= selected register every cycle, so data follows addr with one cycle of latency.
//     A read does not clear anything.
//   Reset mid-debounce: histories are cleared, so a key held through reset reports a new press
//     STABLE_SAMPLES ticks later.
// CONFIGURATION
//   KEY_EVENT_RELEASE_EN
//     defined:   a 1->0 change of STATE[i] sets PENDING[16+i]. These bits are W1C, and MASK bits [16+i]
//                gate them into irq in the same way as the press bits.
//     undefined: PENDING[31:16] and MASK[31:16] read 0, writes to them are ignored, and no release logic
//                is built.
// TESTING (bench: TICK_DIV=4, STABLE_SAMPLES=3, N_KEYS=8)
//   1. Reset: assert reset 2 cycles with keys idle (all 1) -> rdata=0 and irq=0; reading STATE/PENDING/MASK/CTRL
//      returns 0.
//   2. Press key 2 (user_key=8'hFB): STATE=0x04 at the third tick after sync; PENDING=0x04 next cycle;
//      with MASK=0x04, CTRL=1, irq=1 one cycle later.
//   3. Bounce: toggle key 5 every tick for 20 ticks -> STATE[5] and PENDING[5] stay 0, irq stays 0.
//   4. W1C race: write PENDING=0x04 in the same cycle a key-2 press event sets -> PENDING[2] remains 1;
//      a later write of 0x04 clears it and irq drops the next cycle.
//   5. FREEZE: set CTRL=2, press key 0 for 40 cycles -> STATE unchanged; clear FREEZE -> STATE[0]=1
//      after 3 ticks.
//   6. KEY_EVENT_RELEASE_EN: press then release key 7 -> PENDING=0x0080_0080; undefined build -> 0x0000_0080.

Source files
------------

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - push-button synchroniser/debouncer with W1C event register and maskable irq
// Release events are built only when KEY_EVENT_RELEASE_EN is defined.
module key_event_ctrl #(
  parameter int N_KEYS         = 8,
  parameter int TICK_DIV       = 250000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] user_key,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);
  localparam int CW = $clog2(TICK_DIV);

  logic [N_KEYS-1:0]         key_meta_q, key_sync_q, key_pressed;
  logic [CW-1:0]             tick_cnt_q, tick_cnt_d;
  logic                      tick;
  logic [STABLE_SAMPLES-1:0] hist_q [N_KEYS];
  logic [STABLE_SAMPLES-1:0] hist_d [N_KEYS];
  logic [N_KEYS-1:0]         state_q, state_d, state_prev_q;
  logic [N_KEYS-1:0]         press_pend_q, press_pend_d;
  logic [N_KEYS-1:0]         mask_q, mask_d;
  logic [1:0]                ctrl_q, ctrl_d;
  logic                      irq_q, irq_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      wr_pend, wr_mask, wr_ctrl, irq_hit;
  logic                      unused_wdata;
`ifdef KEY_EVENT_RELEASE_EN
  logic [N_KEYS-1:0]         rel_pend_q, rel_pend_d;
  logic [N_KEYS-1:0]         rel_mask_q, rel_mask_d;
`endif

  assign key_pressed  = ~key_sync_q;
  assign wr_pend      = we && (addr == 2'd1);
  assign wr_mask      = we && (addr == 2'd2);
  assign wr_ctrl      = we && (addr == 2'd3);
  assign unused_wdata = ^wdata;
  assign rdata        = rdata_q;
  assign irq          = irq_q;

  // FREEZE stalls the divider, which in turn holds every history and STATE.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick       = 1'b0;
    if (!ctrl_q[1]) begin
      if (tick_cnt_q == CW'(TICK_DIV - 1)) begin
        tick_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < N_KEYS; i++) begin
      hist_d[i] = hist_q[i];
      if (tick) begin
        hist_d[i] = {hist_q[i][STABLE_SAMPLES-2:0], key_pressed[i]};
        if (&hist_d[i]) begin
          state_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          state_d[i] = 1'b0;
        end
      end
    end
  end

  // Clear is applied before set so a same-cycle event survives the write.
  always_comb begin
    press_pend_d = press_pend_q;
    mask_d       = mask_q;
    ctrl_d       = ctrl_q;
    if (wr_pend) press_pend_d = press_pend_d & ~wdata[N_KEYS-1:0];
    press_pend_d = press_pend_d | (state_q & ~state_prev_q);
    if (wr_mask) mask_d = wdata[N_KEYS-1:0];
    if (wr_ctrl) ctrl_d = wdata[1:0];
    irq_hit = |(press_pend_q & mask_q);
`ifdef KEY_EVENT_RELEASE_EN
    rel_pend_d = rel_pend_q;
    rel_mask_d = rel_mask_q;
    if (wr_pend) rel_pend_d = rel_pend_d & ~wdata[16 +: N_KEYS];
    rel_pend_d = rel_pend_d | (~state_q & state_prev_q);
    if (wr_mask) rel_mask_d = wdata[16 +: N_KEYS];
    irq_hit = irq_hit | (|(rel_pend_q & rel_mask_q));
`endif
    irq_d = ctrl_q[0] & irq_hit;
  end

  always_comb begin
    rdata_d = '0;
    case (addr)
      2'd0: rdata_d[N_KEYS-1:0] = state_q;
      2'd1: begin
        rdata_d[N_KEYS-1:0] = press_pend_q;
`ifdef KEY_EVENT_RELEASE_EN
        rdata_d[16 +: N_KEYS] = rel_pend_q;
`endif
      end
      2'd2: begin
        rdata_d[N_KEYS-1:0] = mask_q;
`ifdef KEY_EVENT_RELEASE_EN
        rdata_d[16 +: N_KEYS] = rel_mask_q;
`endif
      end
      default: rdata_d[1:0] = ctrl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_q   <= '1;
      key_sync_q   <= '1;
      tick_cnt_q   <= '0;
      for (int i = 0; i < N_KEYS; i++) hist_q[i] <= '0;
      state_q      <= '0;
      state_prev_q <= '0;
      press_pend_q <= '0;
      mask_q       <= '0;
      ctrl_q       <= '0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
`ifdef KEY_EVENT_RELEASE_EN
      rel_pend_q   <= '0;
      rel_mask_q   <= '0;
`endif
    end else begin
      key_meta_q   <= user_key;
      key_sync_q   <= key_meta_q;
      tick_cnt_q   <= tick_cnt_d;
      for (int i = 0; i < N_KEYS; i++) hist_q[i] <= hist_d[i];
      state_q      <= state_d;
      state_prev_q <= state_q;
      press_pend_q <= press_pend_d;
      mask_q       <= mask_d;
      ctrl_q       <= ctrl_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
`ifdef KEY_EVENT_RELEASE_EN
      rel_pend_q   <= rel_pend_d;
      rel_mask_q   <= rel_mask_d;
`endif
    end
  end
endmodule
